clkdiv_prog: RTL and testbench

Runtime-programmable integer clock divider. Successor to the fixed-N divider, with the divisor width parametrised and the divisor loaded at run time.
- Produces a 50%-duty output for both even and odd divisors.
- Divisor changes apply only at a period boundary, so the output never glitches.
- Also produces a one-cycle tick strobe.
- Sits in the clock/timing group, feeding baud generators and slow peripheral strobes.

---
 rtl/clkdiv_pkg.sv | 18 +
 rtl/clkdiv_cfg.sv | 106 ++++++++++
 rtl/clkdiv_prog.sv | 134 +++++++++++++
 tb/tb_clkdiv_prog.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared constants and helpers for the programmable clock divider.
//   DIV_W_DEF : default width of divisor, counter and high-time values
//   MIN_DIV   : smallest divisor accepted by a load
//   half_ceil : ceil(n/2), the number of posedge cycles the raw high term
//               spends high in one period
// -----------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int MIN_DIV   = 2;

  function automatic int unsigned half_ceil(input int unsigned n);
    return (n + 32'd1) / 32'd2;
  endfunction

endpackage

// File: rtl/clkdiv_cfg.sv
// -----------------------------------------------------------------------------
// clkdiv_cfg
// Divisor shadow register for clkdiv_prog. A load captures a requested
// divisor into a pending register. The pending value becomes the current
// divisor only when the counter asks for it through 'apply', which happens
// at a period boundary or on every cycle while the divider is disabled.
//
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-low reset
//   load     in   one-cycle strobe, capture div into the pending register
//   div      in   requested divisor
//   hi       in   requested high time (only with CLKDIV_DUTY_EN)
//   apply    in   boundary strobe from the counter, pending -> current
//   cur_div  out  divisor in force
//   hi_cur   out  high time in force (only with CLKDIV_DUTY_EN)
//   busy     out  a pending divisor has not been applied yet
//   bad_div  out  one-cycle pulse when a load of div < MIN_DIV is rejected
//
// Optional feature macro: CLKDIV_DUTY_EN (programmable high time).
// -----------------------------------------------------------------------------
module clkdiv_cfg
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
`ifdef CLKDIV_DUTY_EN
  input  logic [DIV_W-1:0] hi,
  output logic [DIV_W-1:0] hi_cur,
`endif
  input  logic             apply,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy,
  output logic             bad_div
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] pend_div;
  logic             div_ok;
  logic             take;

  assign div_ok = (div >= DIV_W'(MIN_DIV));
  assign take   = load & div_ok;

  // Apply uses the pending value as it stood before this edge; a load on the
  // same edge therefore stays pending and keeps busy set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_div  <= DEF_DIV;
      pend_div <= DEF_DIV;
      busy     <= 1'b0;
      bad_div  <= 1'b0;
    end else begin
      bad_div <= load & ~div_ok;
      if (apply) begin
        cur_div <= pend_div;
      end
      if (take) begin
        pend_div <= div;
        busy     <= 1'b1;
      end else if (apply) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef CLKDIV_DUTY_EN
  // Power-on high time: floor half of the power-on divisor, always >= 1.
  localparam logic [DIV_W-1:0] DEF_HI = DIV_W'(DEFAULT_DIV / 2);

  logic [DIV_W-1:0] pend_hi;

  // Keep the high time inside 1..n-1 so out always toggles in each period.
  function automatic logic [DIV_W-1:0] clamp_hi(input logic [DIV_W-1:0] h,
                                                input logic [DIV_W-1:0] n);
    if (h == '0) begin
      return DIV_W'(1);
    end
    if (h >= n) begin
      return n - DIV_W'(1);
    end
    return h;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_hi <= DEF_HI;
      hi_cur  <= DEF_HI;
    end else begin
      if (apply) begin
        hi_cur <= pend_hi;
      end
      if (take) begin
        pend_hi <= clamp_hi(hi, div);
      end
    end
  end
`endif

endmodule

// File: rtl/clkdiv_prog.sv
// -----------------------------------------------------------------------------
// clkdiv_prog
// Runtime-programmable integer clock divider with 50% duty for even and odd
// divisors, a one-cycle tick at the start of each period, and glitch-free
// divisor changes (a new divisor only takes effect at a period boundary).
//
// Ports:
//   clk      in   input clock
//   reset    in   asynchronous active-low reset
//   en       in   divider enable; low holds out low and cnt at 0
//   load     in   one-cycle strobe, request divisor div
//   div      in   requested divisor N (values below 2 are rejected)
//   hi       in   requested high time (only with CLKDIV_DUTY_EN)
//   out      out  divided clock
//   tick     out  one-clk pulse at the start of every period
//   busy     out  requested divisor not yet in force
//   bad_div  out  one-clk pulse when a load with div < 2 is rejected
//
// Optional feature macro: CLKDIV_DUTY_EN. When defined, out is high for
// hi_cur posedge cycles per period and the negedge stage is not used.
// -----------------------------------------------------------------------------
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
`ifdef CLKDIV_DUTY_EN
  input  logic [DIV_W-1:0] hi,
`endif
  output logic             out,
  output logic             tick,
  output logic             busy,
  output logic             bad_div
);

  logic [DIV_W-1:0] cur_div;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last_cnt;
  logic [DIV_W-1:0] hi_lim;
  logic             at_end;
  logic             apply;
  logic             hi_p;

  // cur_div is never below 2, so last_cnt cannot underflow and cnt never
  // exceeds cur_div-1, even for the largest divisor.
  assign last_cnt = cur_div - DIV_W'(1);
  assign at_end   = (cnt == last_cnt);

  // While disabled the counter is parked, so a pending divisor can be taken
  // on any edge without cutting a period short.
  assign apply = ~en | at_end;

  clkdiv_cfg #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_cfg (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .div     (div),
`ifdef CLKDIV_DUTY_EN
    .hi      (hi),
    .hi_cur  (hi_lim),
`endif
    .apply   (apply),
    .cur_div (cur_div),
    .busy    (busy),
    .bad_div (bad_div)
  );

`ifndef CLKDIV_DUTY_EN
  assign hi_lim = DIV_W'(half_ceil(32'(cur_div)));
`endif

  // ---- stage p0: period counter ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // ---- stage p1: registered high term and tick ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_p <= 1'b0;
      tick <= 1'b0;
    end else begin
      hi_p <= en & (cnt < hi_lim);
      tick <= en & (cnt == '0);
    end
  end

`ifdef CLKDIV_DUTY_EN
  assign out = hi_p;
`else
  logic hi_n;
  logic odd_p;

  // Parity is registered together with hi_p so the output select and the
  // gated term always describe the same period across a divisor change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      odd_p <= DIV_W'(DEFAULT_DIV) % DIV_W'(2) != '0;
    end else begin
      odd_p <= cur_div[0];
    end
  end

  // ---- stage n: half-cycle delayed copy of hi_p ----
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      hi_n <= 1'b0;
    end else begin
      hi_n <= hi_p;
    end
  end

  // Odd divisors: hi_p is high for (N+1)/2 cycles; ANDing with its negedge
  // copy removes the first half cycle, leaving exactly N/2 cycles high. The
  // rising edge of out therefore lands on the falling clk edge after tick.
  assign out = odd_p ? (hi_p & hi_n) : hi_p;
`endif

endmodule

// File: tb/tb_clkdiv_prog.sv
module tb_clkdiv_prog;

  localparam int DW = 8;
  localparam int DEF = 9;

  logic          clk;
  logic          reset;
  logic          en;
  logic          load;
  logic [DW-1:0] div;
  logic          out;
  logic          tick;
  logic          busy;
  logic          bad_div;

  clkdiv_prog #(.DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .div     (div),
    .out     (out),
    .tick    (tick),
    .busy    (busy),
    .bad_div (bad_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int rise; int w; } wexp_t;
  typedef struct { bit rst; bit busy; bit bad; } cexp_t;

  wexp_t q_w[$];
  int    q_tick[$];
  cexp_t q_ctl[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model state: periods as (start edge, length) events
  int m_cur, m_pend, m_t, m_n, m_next;
  bit m_busy, m_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: evaluated at every rising edge on the sampled inputs.
  initial begin
    int    w;
    bit    bad;
    wexp_t tmp;
    m_cur = DEF; m_pend = DEF; m_busy = 0; m_run = 0; m_t = 0; m_n = DEF; m_next = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        m_cur = DEF; m_pend = DEF; m_busy = 0; m_run = 0;
        q_w.delete(); q_tick.delete();
        q_ctl.push_back('{1'b1, 1'b0, 1'b0});
      end else begin
        bad = load && (div < 2);
        if (!en) begin
          if (m_run) begin
            w = 2 * (cyc - m_t) - (m_n % 2);
            if (w < m_n && q_w.size() > 0) begin
              tmp = q_w.pop_back();
              tmp.w = w;
              q_w.push_back(tmp);
            end
          end
          m_run = 0;
          m_cur = m_pend;
          m_busy = 0;
        end else begin
          if (!m_run || cyc == m_next) begin
            m_run = 1; m_t = cyc; m_n = m_cur; m_next = cyc + m_cur;
            q_tick.push_back(cyc);
            q_w.push_back('{2 * cyc + (m_cur % 2), m_cur});
          end
          if (cyc == m_next - 1) begin
            m_cur = m_pend;
            m_busy = 0;
          end
        end
        if (load && !bad) begin
          m_pend = int'(div);
          m_busy = 1;
        end
        q_ctl.push_back('{1'b0, m_busy, bad});
      end
    end
  end

  // Monitor: samples 1 time unit after each clock edge.
  initial begin
    int    h;
    int    rise_h;
    bit    prev_out;
    bit    in_hi;
    cexp_t ce;
    wexp_t we;
    prev_out = 0; in_hi = 0; rise_h = 0;
    forever begin
      @(clk);
      #1;
      h = clk ? 2 * cyc : 2 * cyc + 1;
      if (clk) begin
        check("ctl_expected", q_ctl.size() > 0, 1);
        if (q_ctl.size() > 0) begin
          ce = q_ctl.pop_front();
          check("busy", busy, ce.busy);
          check("bad_div", bad_div, ce.bad);
          if (ce.rst) begin
            check("reset_out", out, 0);
            check("reset_tick", tick, 0);
          end
        end
        if (tick === 1'b1) begin
          check("tick_expected", q_tick.size() > 0, 1);
          if (q_tick.size() > 0) check("tick_edge", cyc, q_tick.pop_front());
        end
      end
      if (reset !== 1'b1) begin
        in_hi = 0;
        prev_out = 0;
      end else begin
        if (out === 1'b1 && !prev_out) begin
          in_hi = 1;
          rise_h = h;
        end else if (out === 1'b0 && prev_out && in_hi) begin
          in_hi = 0;
          check("pulse_expected", q_w.size() > 0, 1);
          if (q_w.size() > 0) begin
            we = q_w.pop_front();
            check("out_rise_halfcycle", rise_h, we.rise);
            check("out_high_halfcycles", h - rise_h, we.w);
          end
        end
        prev_out = (out === 1'b1);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input int d);
    @(negedge clk);
    load = 1'b1;
    div = d[DW-1:0];
    @(negedge clk);
    load = 1'b0;
  endtask

  // mode 0: wait until the edge just passed is 'ph' cycles into a period
  // mode 1: wait until the next edge is the model's apply edge
  task automatic wait_until(input int mode, input int ph);
    bit ok;
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      ok = m_run && ((mode == 0) ? (cyc - m_t == ph) : (cyc + 1 == m_next - 1));
    end
    check("phase_wait", ok, 1);
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; load = 1'b0; div = '0;
    run(3);
    reset = 1'b1;
    // default divisor, free running
    run(30);
    // switch to 4 mid-period
    wait_until(0, 3);
    pulse_load(4);
    run(30);
    // rejected loads
    pulse_load(1);
    pulse_load(0);
    run(10);
    // last load before the boundary wins
    pulse_load(5);
    run(1);
    pulse_load(6);
    run(30);
    // disable during the high phase, re-enable after 20 cycles
    wait_until(0, 1);
    en = 1'b0;
    @(posedge clk);
    #1 check("en_off_out", out, 0);
    run(20);
    en = 1'b1;
    run(30);
    // load landing exactly on the apply edge stays pending
    wait_until(1, 0);
    load = 1'b1; div = 8'd3;
    @(negedge clk);
    load = 1'b0;
    run(20);
    // reset mid-period with a pending divisor
    wait_until(0, 1);
    pulse_load(7);
    reset = 1'b0;
    #1 check("async_reset_out", out, 0);
    check("async_reset_busy", busy, 0);
    run(3);
    reset = 1'b1;
    run(30);
    // largest divisor
    pulse_load(255);
    run(560);
    pulse_load(6);
    run(20);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) en = ~en;
      load = ($urandom_range(0, 6) == 0);
      div = 8'($urandom_range(0, 13));
    end
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    run(30);
    en = 1'b0;
    run(4);
    check("tick_queue_drained", q_tick.size(), 0);
    check("pulse_queue_drained", q_w.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
